full_adder: RTL and testbench

- Ripple-carry adder of WIDTH bits; default WIDTH=1 is a classic single-bit full adder.
- Combinational sum/carry outputs give zero-latency results, so checks may be made combinationally after inputs settle.
- Registered copies of the same results are provided for pipelined consumers.
- Used as a leaf arithmetic cell in datapaths.

---
 rtl/full_adder_pkg.sv | 17 +
 rtl/full_adder_fa_cell.sv | 28 ++
 rtl/full_adder.sv | 64 ++++++
 tb/tb_full_adder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared definitions for the ripple-carry adder slice.
//   DEFAULT_WIDTH : operand width used when full_adder is not parameterised
//   fa_carry()    : carry-out of one bit position from generate/propagate/carry-in
// -----------------------------------------------------------------------------
package full_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  // A bit position produces a carry if it generates one itself, or if it
  // propagates the carry arriving from the bit below.
  function automatic logic fa_carry(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Single-bit full-adder cell, the ripple element of full_adder.
//   a, b : operand bits
//   ci   : carry into this bit position
//   s    : sum bit
//   c    : carry out of this bit position
//   p    : propagate (a ^ b), exported so the top can assemble wire_1
// -----------------------------------------------------------------------------
module fa_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c,
  output logic p
);

  logic g;

  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ ci;
  assign c = fa_carry(g, p, ci);

endmodule : fa_cell

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// WIDTH-bit ripple-carry adder with combinational and registered results.
//   clk   : clock, used only by the registered outputs
//   rst_n : synchronous active-low reset of sum_q/co_q
//   a, b  : WIDTH-bit operands
//   ci    : carry-in
//   sum   : (a + b + ci) mod 2^WIDTH, combinational
//   co    : bit WIDTH of a + b + ci, combinational
//   sum_q : sum registered on rising clk
//   co_q  : co registered on rising clk
// -----------------------------------------------------------------------------
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic [WIDTH-1:0] sum_q,
  output logic             co_q
);

  // Propagate vector (a ^ b). Kept as a named top-level signal so that it
  // can be observed hierarchically.
  logic [WIDTH-1:0] wire_1;

  // c[i] is the carry into bit i; c[WIDTH] is the final carry-out.
  logic [WIDTH:0]   c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .c  (c[i+1]),
      .p  (wire_1[i])
    );
  end

  assign co = c[WIDTH];

  // Registered copy for pipelined consumers; reset clears only these, the
  // combinational outputs keep tracking the inputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value.
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum;
      co_q  <= co;
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Checks a 1-bit and an 8-bit full_adder against an arithmetic model, plus
// directed vectors with hand-computed results.
// -----------------------------------------------------------------------------
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a1, b1, ci1;
  logic       sum1, co1, sum_q1, co_q1;

  logic [7:0] a8, b8;
  logic       ci8;
  logic [7:0] sum8, sum_q8;
  logic       co8, co_q8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a1),
    .b     (b1),
    .ci    (ci1),
    .sum   (sum1),
    .co    (co1),
    .sum_q (sum_q1),
    .co_q  (co_q1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a8),
    .b     (b8),
    .ci    (ci8),
    .sum   (sum8),
    .co    (co8),
    .sum_q (sum_q8),
    .co_q  (co_q8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: plain arithmetic at WIDTH+1 bits ----------------
  logic [1:0] exp1_q;
  logic [8:0] exp8_q;
  bit         reg_valid = 1'b0;
  bit         done      = 1'b0;

  function automatic logic [1:0] add1(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction

  function automatic logic [8:0] add8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return 9'(a) + 9'(b) + 9'(c);
  endfunction

  // Registered expectation: what the flops must hold after this edge.
  always @(posedge clk) begin
    exp1_q    = rst_n ? add1(a1, b1, ci1) : 2'b00;
    exp8_q    = rst_n ? add8(a8, b8, ci8) : 9'h000;
    reg_valid = 1'b1;
  end

  // Compare process: every falling edge, away from input changes and clk rise.
  always @(negedge clk) begin
    if (!done) begin
      check("m_comb1", {30'd0, co1, sum1}, {30'd0, add1(a1, b1, ci1)});
      check("m_comb8", {23'd0, co8, sum8}, {23'd0, add8(a8, b8, ci8)});
      check("m_prop1", {31'd0, dut.wire_1}, {31'd0, a1 ^ b1});
      check("m_prop8", {24'd0, dut8.wire_1}, {24'd0, a8 ^ b8});
      if (reg_valid) begin
        check("m_reg1", {30'd0, co_q1, sum_q1}, {30'd0, exp1_q});
        check("m_reg8", {23'd0, co_q8, sum_q8}, {23'd0, exp8_q});
      end
    end
  end

  // Drive a new vector shortly after a rising edge.
  task automatic apply(input logic ia1, input logic ib1, input logic ic1,
                       input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8);
    @(posedge clk);
    #2;
    a1 = ia1; b1 = ib1; ci1 = ic1;
    a8 = ia8; b8 = ib8; ci8 = ic8;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [8:0] exp;  // hand-computed {co,sum}
  } vec8_t;

  vec8_t vecs[10] = '{
    '{8'hFF, 8'h00, 1'b1, 9'h100},
    '{8'hFF, 8'hFF, 1'b1, 9'h1FF},
    '{8'h00, 8'h00, 1'b0, 9'h000},
    '{8'h0F, 8'h01, 1'b0, 9'h010},
    '{8'h80, 8'h80, 1'b0, 9'h100},
    '{8'hA5, 8'h5A, 1'b0, 9'h0FF},
    '{8'hA5, 8'h5A, 1'b1, 9'h100},
    '{8'h7F, 8'h01, 1'b0, 9'h080},
    '{8'h3C, 8'hC3, 1'b1, 9'h100},
    '{8'h12, 8'h34, 1'b1, 9'h047}
  };

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    check("rst_sum_q1", {31'd0, sum_q1}, 32'd0);
    check("rst_co_q1",  {31'd0, co_q1},  32'd0);
    check("rst_sum_q8", {24'd0, sum_q8}, 32'd0);

    // Zero case, then a clock with reset released.
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("zero_comb1", {30'd0, co1, sum1}, 32'd0);
    check("zero_comb8", {23'd0, co8, sum8}, 32'd0);
    @(posedge clk); #1;
    check("zero_reg1", {30'd0, co_q1, sum_q1}, 32'd0);

    // ci only: combinational result within 1 time unit, no clock involved.
    apply(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    #1;
    check("ci_only1", {30'd0, co1, sum1}, 32'b01);
    check("ci_only8", {23'd0, co8, sum8}, 32'h001);

    // 1+1+0 -> 2'b10, propagate 0.
    apply(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
    #1;
    check("two1",       {30'd0, co1, sum1}, 32'b10);
    check("two_prop1",  {31'd0, dut.wire_1}, 32'd0);

    // 1+1+1 -> 2'b11, propagate 0; registered after next edge.
    apply(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    #1;
    check("three1",      {30'd0, co1, sum1}, 32'b11);
    check("three_prop1", {31'd0, dut.wire_1}, 32'd0);
    check("max8",        {23'd0, co8, sum8}, 32'h1FF);
    @(posedge clk); #1;
    check("three_reg1",  {30'd0, co_q1, sum_q1}, 32'b11);
    check("max_reg8",    {23'd0, co_q8, sum_q8}, 32'h1FF);

    // Reset mid-operation: registers clear, combinational keeps tracking.
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_reg1",  {30'd0, co_q1, sum_q1}, 32'd0);
    check("mid_rst_reg8",  {23'd0, co_q8, sum_q8}, 32'd0);
    check("mid_rst_comb1", {30'd0, co1, sum1}, 32'b11);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_reg1", {30'd0, co_q1, sum_q1}, 32'b11);

    // 8-bit directed vectors with hand-computed results.
    foreach (vecs[i]) begin
      apply(vecs[i].a[0], vecs[i].b[0], vecs[i].ci, vecs[i].a, vecs[i].b, vecs[i].ci);
      #1;
      check($sformatf("vec8_%0d", i), {23'd0, co8, sum8}, {23'd0, vecs[i].exp});
      check($sformatf("vec8_prop_%0d", i), {24'd0, dut8.wire_1}, {24'd0, vecs[i].a ^ vecs[i].b});
    end

    // Random sweep, checked by the model every cycle.
    for (int i = 0; i < 200; i++) begin
      apply(1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_full_adder
